// File: rtl/mini_alu_core_if.sv
`default_nettype none
// ============================================================================
// Module  : mini_alu_core_if
// Purpose : ROM fetch port and board-facing status/LED signals of mini_alu_core
// Revision: 1.0
// ============================================================================
interface mini_alu_core_if #(
  parameter int REG_ADDR_WIDTH = 8,
  parameter int IP_WIDTH       = 16,
  parameter int LED_WIDTH      = 8
);
  localparam int c_instr_w = 4 + 3 * REG_ADDR_WIDTH;

  logic [c_instr_w-1:0] iInstruction;
  logic [IP_WIDTH-1:0]  oIP;
  logic [LED_WIDTH-1:0] oLed;
  logic                 oBusy;
  logic                 oHalted;

  modport master (
    input  iInstruction,
    output oIP,
    output oLed,
    output oBusy,
    output oHalted
  );

  modport slave (
    output iInstruction,
    input  oIP,
    input  oLed,
    input  oBusy,
    input  oHalted
  );
endinterface
`default_nettype wire

// File: rtl/mini_alu_core.sv
`default_nettype none
// ============================================================================
// Module  : mini_alu_core
// Purpose : two-stage fetch/execute ALU core; MINI_ALU_CORE_MUL_EN builds the
//           multi-cycle shift-add multiplier, otherwise opcode 7 is a NOP
// Revision: 1.0
// ============================================================================
module mini_alu_core #(
  parameter int DATA_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 8,
  parameter int IP_WIDTH       = 16,
  parameter int LED_WIDTH      = 8
) (
  input  logic            Clock,
  input  logic            Reset,
  mini_alu_core_if.master bus
);

  localparam int c_instr_w = 4 + 3 * REG_ADDR_WIDTH;
  localparam int c_depth   = 2 ** REG_ADDR_WIDTH;

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_sto  = 4'h1;
  localparam logic [3:0] c_op_add  = 4'h2;
  localparam logic [3:0] c_op_sub  = 4'h3;
  localparam logic [3:0] c_op_ble  = 4'h4;
  localparam logic [3:0] c_op_jmp  = 4'h5;
  localparam logic [3:0] c_op_led  = 4'h6;
  localparam logic [3:0] c_op_and  = 4'h8;
  localparam logic [3:0] c_op_or   = 4'h9;
  localparam logic [3:0] c_op_xor  = 4'hA;
  localparam logic [3:0] c_op_shl  = 4'hB;
  localparam logic [3:0] c_op_shr  = 4'hC;
  localparam logic [3:0] c_op_halt = 4'hF;

  localparam logic [DATA_WIDTH:0]  c_dw_ext  = (DATA_WIDTH + 1)'(DATA_WIDTH);
  localparam logic [IP_WIDTH-1:0]  c_ip_one  = IP_WIDTH'(1);
  localparam logic [c_instr_w-1:0] c_ex_nop  = {c_op_nop, {(c_instr_w - 4){1'b0}}};

`ifdef MINI_ALU_CORE_MUL_EN
  localparam int c_cnt_w = $clog2(DATA_WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MUL_RUN = 1'b1
  } mul_state_t;

  mul_state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [DATA_WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [DATA_WIDTH-1:0]     acc_q, acc_d;
  logic [c_cnt_w-1:0]        cnt_q, cnt_d;
  logic [REG_ADDR_WIDTH-1:0] mul_dst_q, mul_dst_d;
  logic [DATA_WIDTH-1:0]     mul_addend;
`endif

  logic [IP_WIDTH-1:0]   ip_q, ip_d;
  logic [c_instr_w-1:0]  ex_q, ex_d;
  logic [LED_WIDTH-1:0]  led_q, led_d;
  logic                  halted_q, halted_d;
  logic [DATA_WIDTH-1:0] regs_q [c_depth];

  logic                      rf_we;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;

  logic [3:0]                op;
  logic [REG_ADDR_WIDTH-1:0] dst, src1, src0;
  logic [DATA_WIDTH-1:0]     rs1, rs0, imm;
  logic [IP_WIDTH-1:0]       target, fetch_ip;
  logic                      ex_run, take_branch, shamt_big;

  assign op     = ex_q[c_instr_w-1 -: 4];
  assign dst    = ex_q[3*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign src1   = ex_q[2*REG_ADDR_WIDTH-1 -: REG_ADDR_WIDTH];
  assign src0   = ex_q[REG_ADDR_WIDTH-1:0];
  assign rs1    = regs_q[src1];
  assign rs0    = regs_q[src0];
  assign imm    = DATA_WIDTH'({src1, src0});
  assign target = IP_WIDTH'(dst);

  // EX is frozen while a multiply iterates, so nothing in it may act yet.
`ifdef MINI_ALU_CORE_MUL_EN
  assign ex_run = !halted_q && (state_q == ST_IDLE);
`else
  assign ex_run = !halted_q;
`endif

  assign take_branch = ex_run && ((op == c_op_jmp) || ((op == c_op_ble) && (rs1 <= rs0)));
  assign fetch_ip    = take_branch ? target : ip_q;
  assign shamt_big   = ({1'b0, rs0} >= c_dw_ext);

  assign bus.oIP     = fetch_ip;
  assign bus.oLed    = led_q;
  assign bus.oHalted = halted_q;
`ifdef MINI_ALU_CORE_MUL_EN
  assign bus.oBusy   = (state_q == ST_MUL_RUN);
  assign mul_addend  = mul_b_q[0] ? mul_a_q : '0;
`else
  assign bus.oBusy   = 1'b0;
`endif

  always_comb begin
    ip_d     = ip_q;
    ex_d     = ex_q;
    led_d    = led_q;
    halted_d = halted_q;
    rf_we    = 1'b0;
    rf_waddr = dst;
    rf_wdata = '0;
`ifdef MINI_ALU_CORE_MUL_EN
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mul_dst_d = mul_dst_q;
`endif

    if (halted_q) begin
      ex_d = c_ex_nop;
    end
`ifdef MINI_ALU_CORE_MUL_EN
    else if (state_q == ST_MUL_RUN) begin
      acc_d   = acc_q + mul_addend;
      mul_a_d = mul_a_q << 1;
      mul_b_d = mul_b_q >> 1;
      cnt_d   = cnt_q + c_cnt_one;
      if (cnt_q == c_cnt_last) begin
        rf_we    = 1'b1;
        rf_waddr = mul_dst_q;
        rf_wdata = acc_q + mul_addend;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
    end
`endif
    else begin
      ip_d = fetch_ip + c_ip_one;
      ex_d = bus.iInstruction;
      case (op)
        c_op_sto: begin rf_we = 1'b1; rf_wdata = imm;       end
        c_op_add: begin rf_we = 1'b1; rf_wdata = rs1 + rs0; end
        c_op_sub: begin rf_we = 1'b1; rf_wdata = rs1 - rs0; end
        c_op_and: begin rf_we = 1'b1; rf_wdata = rs1 & rs0; end
        c_op_or:  begin rf_we = 1'b1; rf_wdata = rs1 | rs0; end
        c_op_xor: begin rf_we = 1'b1; rf_wdata = rs1 ^ rs0; end
        c_op_shl: begin rf_we = 1'b1; rf_wdata = shamt_big ? '0 : (rs1 << rs0); end
        c_op_shr: begin rf_we = 1'b1; rf_wdata = shamt_big ? '0 : (rs1 >> rs0); end
        c_op_led: led_d = rs1[LED_WIDTH-1:0];
`ifdef MINI_ALU_CORE_MUL_EN
        4'h7: begin
          mul_a_d   = rs1;
          mul_b_d   = rs0;
          acc_d     = '0;
          cnt_d     = '0;
          mul_dst_d = dst;
          state_d   = ST_MUL_RUN;
        end
`endif
        // The word fetched alongside HALT is dropped and the IP parks on it.
        c_op_halt: begin
          halted_d = 1'b1;
          ex_d     = c_ex_nop;
          ip_d     = ip_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ip_q     <= '0;
      ex_q     <= c_ex_nop;
      led_q    <= '0;
      halted_q <= 1'b0;
`ifdef MINI_ALU_CORE_MUL_EN
      state_q   <= ST_IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mul_dst_q <= '0;
`endif
    end else begin
      ip_q     <= ip_d;
      ex_q     <= ex_d;
      led_q    <= led_d;
      halted_q <= halted_d;
`ifdef MINI_ALU_CORE_MUL_EN
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      mul_dst_q <= mul_dst_d;
`endif
    end
  end

  // Register file keeps its contents across reset; a reset edge blocks any write.
  always_ff @(posedge Clock) begin
    if (rf_we && !Reset) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mini_alu_core.sv
`default_nettype none
// Testbench for mini_alu_core: program-driven scenarios with an LED scoreboard.
module tb_mini_alu_core;
  localparam int RAW = 8;
  localparam int IW  = 4 + 3 * RAW;

  localparam logic [3:0] OP_NOP = 4'h0, OP_STO = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3;
  localparam logic [3:0] OP_BLE = 4'h4, OP_JMP = 4'h5, OP_LED = 4'h6, OP_MUL = 4'h7;
  localparam logic [3:0] OP_AND = 4'h8, OP_OR = 4'h9, OP_XOR = 4'hA, OP_SHL = 4'hB;
  localparam logic [3:0] OP_SHR = 4'hC, OP_HALT = 4'hF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mini_alu_core_if #(.REG_ADDR_WIDTH(8), .IP_WIDTH(16), .LED_WIDTH(8)) bus ();

  mini_alu_core #(
    .DATA_WIDTH(16), .REG_ADDR_WIDTH(8), .IP_WIDTH(16), .LED_WIDTH(8)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  logic [IW-1:0] rom [256];
  assign bus.iInstruction = rom[bus.oIP[7:0]];

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] led_prev = 8'h00;
  logic [7:0] exp_led;

  function automatic logic [IW-1:0] ins(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s0);
    return {op, d, s1, s0};
  endfunction

  function automatic logic [IW-1:0] sto(input logic [7:0] d, input logic [15:0] imm);
    return {OP_STO, d, imm[15:8], imm[7:0]};
  endfunction

  // Scoreboard: every change of oLed outside reset consumes one expected value.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      led_prev = bus.oLed;
    end else if (bus.oLed !== led_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL led_unexpected: oLed=%h with no expected value pending", bus.oLed);
      end else begin
        exp_led = exp_q.pop_front();
        if (bus.oLed !== exp_led) begin
          errors++;
          $display("FAIL led_value: oLed=%h expected %h", bus.oLed, exp_led);
        end
      end
      led_prev = bus.oLed;
    end
  end

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = '0;
  endtask

  task automatic start_program();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.oIP !== 16'h0)  begin errors++; $display("FAIL reset_ip: got %h want 0000", bus.oIP); end
    checks++; if (bus.oLed !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", bus.oLed); end
    checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.oBusy); end
    checks++; if (bus.oHalted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.oHalted); end
    @(negedge clk) rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.oIP !== 16'(k)) begin errors++; $display("FAIL reset_ip_seq[%0d]: got %h want %h", k, bus.oIP, 16'(k)); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arith();
    logic [15:0] a, b;
    a = 16'd7; b = 16'd5;
    clear_rom();
    rom[0]  = sto(1, a);               rom[1]  = sto(2, b);
    rom[2]  = ins(OP_ADD, 3, 1, 2);    rom[3]  = ins(OP_LED, 0, 3, 0);
    rom[4]  = ins(OP_SUB, 4, 2, 1);    rom[5]  = ins(OP_LED, 0, 4, 0);
    rom[6]  = sto(8, 16'd8);           rom[7]  = ins(OP_SHR, 5, 4, 8);
    rom[8]  = ins(OP_LED, 0, 5, 0);    rom[9]  = ins(OP_AND, 6, 4, 3);
    rom[10] = ins(OP_LED, 0, 6, 0);    rom[11] = ins(OP_OR, 6, 1, 8);
    rom[12] = ins(OP_LED, 0, 6, 0);    rom[13] = ins(OP_XOR, 6, 4, 2);
    rom[14] = ins(OP_LED, 0, 6, 0);    rom[15] = ins(OP_SHL, 6, 1, 1);
    rom[16] = ins(OP_LED, 0, 6, 0);    rom[17] = sto(9, 16'd16);
    rom[18] = ins(OP_SHR, 6, 4, 9);    rom[19] = ins(OP_LED, 0, 6, 0);
    rom[20] = sto(10, 16'd1);          rom[21] = ins(OP_SHL, 6, 4, 10);
    rom[22] = ins(OP_LED, 0, 6, 0);    rom[23] = ins(OP_ADD, 1, 1, 1);
    rom[24] = ins(OP_LED, 0, 1, 0);    rom[25] = ins(4'hD, 1, 1, 1);
    rom[26] = ins(OP_JMP, 26, 0, 0);
    exp_q.push_back(8'(a + b));
    exp_q.push_back(8'(b - a));
    exp_q.push_back(8'((b - a) >> 8));
    exp_q.push_back(8'((b - a) & (a + b)));
    exp_q.push_back(8'(a | 16'd8));
    exp_q.push_back(8'((b - a) ^ b));
    exp_q.push_back(8'(a << a));
    exp_q.push_back(8'h00);
    exp_q.push_back(8'((b - a) << 1));
    exp_q.push_back(8'(a + a));
    start_program();
    repeat (35) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL arith_drain: %0d LED values missing, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_branch();
    int exp_ip [16] = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 5, 6, 6, 6, 6};
    clear_rom();
    rom[0] = sto(1, 16'd3);           rom[1] = sto(2, 16'd1);
    rom[2] = ins(OP_LED, 0, 1, 0);    rom[3] = ins(OP_SUB, 1, 1, 2);
    rom[4] = ins(OP_BLE, 2, 2, 1);    rom[5] = ins(OP_LED, 0, 1, 0);
    rom[6] = ins(OP_JMP, 6, 0, 0);
    exp_q.push_back(8'd3); exp_q.push_back(8'd2);
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    start_program();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.oIP !== 16'(exp_ip[k])) begin
        errors++; $display("FAIL branch_ip[%0d]: got %h want %h", k, bus.oIP, 16'(exp_ip[k]));
      end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL branch_drain: %0d LED values missing, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic load_mul_program();
    clear_rom();
    rom[0] = sto(1, 16'd300);         rom[1] = sto(2, 16'd300);
    rom[2] = sto(3, 16'h0011);        rom[3] = ins(OP_MUL, 3, 1, 2);
    rom[4] = ins(OP_LED, 0, 3, 0);    rom[5] = ins(OP_JMP, 5, 0, 0);
  endtask

  task automatic test_mul();
    int busy_cnt, first_busy, ip_bad, exp_busy;
    logic [15:0] prod;
    busy_cnt = 0; first_busy = -1; ip_bad = 0;
    load_mul_program();
`ifdef MINI_ALU_CORE_MUL_EN
    prod = 16'd300 * 16'd300;
    exp_busy = 16;
`else
    prod = 16'h0011;
    exp_busy = 0;
`endif
    exp_q.push_back(prod[7:0]);
    start_program();
    for (int k = 0; k < 30; k++) begin
      if (bus.oBusy === 1'b1) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = k;
        if (bus.oIP !== 16'd5) ip_bad++;
      end
      @(posedge clk); #1;
    end
    #1;
    checks++;
    if (busy_cnt != exp_busy) begin errors++; $display("FAIL mul_busy_cycles: got %0d want %0d", busy_cnt, exp_busy); end
    checks++;
    if (ip_bad != 0) begin errors++; $display("FAIL mul_ip_hold: %0d busy cycles with oIP != 0005, want 0", ip_bad); end
`ifdef MINI_ALU_CORE_MUL_EN
    checks++;
    if (first_busy != 5) begin errors++; $display("FAIL mul_busy_start: got cycle %0d want 5", first_busy); end
`endif
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL mul_drain: %0d LED values missing, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_mul_reset();
    logic exp_busy;
    load_mul_program();
`ifdef MINI_ALU_CORE_MUL_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
    exp_q.push_back(8'h11);
`endif
    start_program();
    repeat (9) @(negedge clk);
    checks++;
    if (bus.oBusy !== exp_busy) begin errors++; $display("FAIL abort_busy_before: got %b want %b", bus.oBusy, exp_busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", bus.oBusy); end
    checks++;
    if (bus.oIP !== 16'h0) begin errors++; $display("FAIL abort_ip: got %h want 0000", bus.oIP); end
    clear_rom();
    rom[0] = ins(OP_LED, 0, 3, 0);
    rom[1] = ins(OP_JMP, 1, 0, 0);
    exp_q.push_back(8'h11);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL abort_drain: %0d LED values missing, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = sto(1, 16'h0055);        rom[1] = ins(OP_LED, 0, 1, 0);
    rom[2] = sto(2, 16'h00AA);        rom[6] = ins(OP_HALT, 0, 0, 0);
    rom[7] = ins(OP_LED, 0, 2, 0);    rom[8] = ins(OP_LED, 0, 2, 0);
    exp_q.push_back(8'h55);
    start_program();
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (bus.oHalted !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", bus.oHalted); end
    checks++;
    if (bus.oIP !== 16'd7) begin errors++; $display("FAIL halt_fetch_ip: got %h want 0007", bus.oIP); end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.oHalted !== 1'b1) begin errors++; $display("FAIL halt_flag[%0d]: got %b want 1", k, bus.oHalted); end
      checks++;
      if (bus.oIP !== 16'd7) begin errors++; $display("FAIL halt_ip[%0d]: got %h want 0007", k, bus.oIP); end
    end
    checks++;
    if (bus.oLed !== 8'h55) begin errors++; $display("FAIL halt_led: got %h want 55", bus.oLed); end
    #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL halt_drain: %0d LED values missing, want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_branch();
    test_mul();
    test_mul_reset();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
